ext_mem_sequencer: RTL

Host-side initiator for the CPU's two external memory ports (instruction memory and data memory).
- Streams a program image from a valid/ready input into instruction memory.
- Asserts the CPU enable for a programmed number of cycles.
- Reads back a programmed range of data memory onto a valid/ready output stream.
- Sits between the testbench/host link and the cpu top, replacing hand-driven ext-port stimulus.

---
 rtl/ext_seq_pkg.sv | 28 ++
 rtl/seq_down_counter.sv | 29 ++
 rtl/ext_mem_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ext_seq_pkg.sv
// rtl/ext_seq_pkg.sv - shared state type, defaults and phase selection for ext_mem_sequencer
package ext_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_LOAD_LAST = 3'd2,
    ST_RUN       = 3'd3,
    ST_DUMP_REQ  = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_DUMP_OUT  = 3'd6,
    ST_DONE      = 3'd7
  } seq_state_t;

  localparam int DEF_ADDR_STEP = 8;
  localparam int DEF_RD_LAT    = 1;

  // Earliest phase that still has work; a zero count never costs a cycle.
  function automatic seq_state_t first_phase(input logic load_nz,
                                             input logic run_nz,
                                             input logic dump_nz);
    if (load_nz)      return ST_LOAD;
    else if (run_nz)  return ST_RUN;
    else if (dump_nz) return ST_DUMP_REQ;
    else              return ST_DONE;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down counter with zero and one flags
module seq_down_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero,
  output logic             o_one
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_zero = (r_count == '0);
  assign o_one  = (r_count == CNT_W'(1));

endmodule

// File: rtl/ext_mem_sequencer.sv
// rtl/ext_mem_sequencer.sv - streams a program into imem, runs the CPU, dumps a dmem range
module ext_mem_sequencer
  import ext_seq_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int CNT_W     = 16,
  parameter int ADDR_STEP = DEF_ADDR_STEP,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  load_words,
  input  logic [CNT_W-1:0]  run_cycles,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [CNT_W-1:0]  dump_words,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic              ren_ext,
  output logic [DATA_W-1:0] wdata_ext,
  output logic [ADDR_W-1:0] addr_ext_2,
  output logic              wen_ext_2,
  output logic              ren_ext_2,
  output logic [DATA_W-1:0] wdata_ext_2,
  input  logic [DATA_W-1:0] rdata_ext_2,
  output logic              cpu_enable,
  output logic              busy,
  output logic              done
);

  localparam int WAIT_W = 8;

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic              r_s_ready;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_last;
  logic [ADDR_W-1:0] r_addr_ext;
  logic              r_wen_ext;
  logic [DATA_W-1:0] r_wdata_ext;
  logic [ADDR_W-1:0] r_addr_ext_2;
  logic              r_ren_ext_2;
  logic              r_cpu_enable;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_load_ptr;
  logic [WAIT_W-1:0] r_wait;

  logic w_start;
  logic w_s_hs;
  logic w_m_hs;
  logic w_load_zero;
  logic w_load_one;
  logic w_run_zero;
  logic w_run_one;
  logic w_dump_zero;
  logic w_dump_one;

  assign w_start = (r_state == ST_IDLE) && start;
  assign w_s_hs  = s_valid && r_s_ready;
  assign w_m_hs  = r_m_valid && m_ready;

  seq_down_counter #(.CNT_W(CNT_W)) u_load_cnt (
    .clk(clk), .arst_n(arst_n), .i_load(w_start), .i_load_val(load_words),
    .i_dec(w_s_hs), .o_zero(w_load_zero), .o_one(w_load_one)
  );

  seq_down_counter #(.CNT_W(CNT_W)) u_run_cnt (
    .clk(clk), .arst_n(arst_n), .i_load(w_start), .i_load_val(run_cycles),
    .i_dec(r_state == ST_RUN), .o_zero(w_run_zero), .o_one(w_run_one)
  );

  seq_down_counter #(.CNT_W(CNT_W)) u_dump_cnt (
    .clk(clk), .arst_n(arst_n), .i_load(w_start), .i_load_val(dump_words),
    .i_dec(w_m_hs), .o_zero(w_dump_zero), .o_one(w_dump_one)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_state_nxt = first_phase(load_words != '0, run_cycles != '0,
                                                         dump_words != '0);
      ST_LOAD:      if (w_s_hs && (w_load_one || w_load_zero)) w_state_nxt = ST_LOAD_LAST;
      ST_LOAD_LAST: w_state_nxt = first_phase(1'b0, !w_run_zero, !w_dump_zero);
      ST_RUN:       if (w_run_one || w_run_zero) w_state_nxt = first_phase(1'b0, 1'b0, !w_dump_zero);
      ST_DUMP_REQ:  w_state_nxt = ST_DUMP_WAIT;
      ST_DUMP_WAIT: if (r_wait == '0) w_state_nxt = ST_DUMP_OUT;
      ST_DUMP_OUT:  if (w_m_hs) w_state_nxt = w_dump_one ? ST_DONE : ST_DUMP_REQ;
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so each lines up with its state's cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= ST_IDLE;
      r_s_ready    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_addr_ext   <= '0;
      r_wen_ext    <= 1'b0;
      r_wdata_ext  <= '0;
      r_addr_ext_2 <= '0;
      r_ren_ext_2  <= 1'b0;
      r_cpu_enable <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ptr   <= '0;
      r_wait       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_s_ready    <= (w_state_nxt == ST_LOAD);
      r_cpu_enable <= (w_state_nxt == ST_RUN);
      r_ren_ext_2  <= (w_state_nxt == ST_DUMP_REQ);
      r_m_valid    <= (w_state_nxt == ST_DUMP_OUT);
      r_done       <= (w_state_nxt == ST_DONE);
      r_busy       <= (w_state_nxt != ST_IDLE);
      r_wen_ext    <= w_s_hs;

      if (w_start) begin
        r_load_ptr   <= '0;
        r_addr_ext_2 <= dump_base;
      end

      if (w_s_hs) begin
        r_addr_ext  <= r_load_ptr;
        r_wdata_ext <= s_data;
        r_load_ptr  <= r_load_ptr + ADDR_W'(ADDR_STEP);
      end

      if (r_state == ST_DUMP_REQ) begin
        r_wait <= WAIT_W'(RD_LAT - 1);
      end else if ((r_state == ST_DUMP_WAIT) && (r_wait != '0)) begin
        r_wait <= r_wait - WAIT_W'(1);
      end

      if ((r_state == ST_DUMP_WAIT) && (r_wait == '0)) begin
        r_m_data <= rdata_ext_2;
        r_m_last <= w_dump_one;
      end

      // The read pointer doubles as addr_ext_2, so it advances only once a word is consumed.
      if (w_m_hs) begin
        r_m_last     <= 1'b0;
        r_addr_ext_2 <= r_addr_ext_2 + ADDR_W'(ADDR_STEP);
      end
    end
  end

  assign s_ready     = r_s_ready;
  assign m_valid     = r_m_valid;
  assign m_data      = r_m_data;
  assign m_last      = r_m_last;
  assign addr_ext    = r_addr_ext;
  assign wen_ext     = r_wen_ext;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = r_wdata_ext;
  assign addr_ext_2  = r_addr_ext_2;
  assign wen_ext_2   = 1'b0;
  assign ren_ext_2   = r_ren_ext_2;
  assign wdata_ext_2 = '0;
  assign cpu_enable  = r_cpu_enable;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule
